// File: rtl/ram_bus_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ram_bus_pkg : shared types, state codes and defaults for RAM bus    |
// | Revision    : 1.0                                                   |
// +---------------------------------------------------------------------+
package ram_bus_pkg;

  localparam int c_DEF_ADDR_W    = 8;
  localparam int c_DEF_DATA_W    = 32;
  localparam int c_DEF_READ_LAT  = 2;
  localparam int c_DEF_WRITE_CYC = 1;

  typedef logic [2:0] state_t;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_READ  = 3'd1;
  localparam logic [2:0] c_ST_RESP  = 3'd2;
  localparam logic [2:0] c_ST_WRITE = 3'd3;
  localparam logic [2:0] c_ST_TURN  = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_wait_counter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ram_wait_counter : phase cycle counter with last-cycle flag         |
// | Revision         : 1.0                                              |
// +---------------------------------------------------------------------+
module ram_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Cleared at acceptance, so the count in phase cycle k is k-1.
  assign o_last = (r_count == (i_limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/ram_bus_master.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ram_bus_master : single-request initiator for the shared RAM bus    |
// | Revision       : 1.0                                                |
// +---------------------------------------------------------------------+
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W    = c_DEF_ADDR_W,
  parameter int DATA_W    = c_DEF_DATA_W,
  parameter int READ_LAT  = c_DEF_READ_LAT,
  parameter int WRITE_CYC = c_DEF_WRITE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              wr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int c_CNT_W = $clog2(max_int(READ_LAT, WRITE_CYC)) + 1;
  localparam logic [c_CNT_W-1:0] c_READ_LIM  = c_CNT_W'(READ_LAT);
  localparam logic [c_CNT_W-1:0] c_WRITE_LIM = c_CNT_W'(WRITE_CYC);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_rd_en;
  logic                r_wr_en;
  logic                r_resp_valid;
  logic                r_wr_done;

  logic                w_accept;
  logic                w_cnt_en;
  logic                w_last;
  logic [c_CNT_W-1:0]  w_limit;

  assign req_ready = (r_state == c_ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_cnt_en  = (r_state == c_ST_READ) || (r_state == c_ST_WRITE);
  assign w_limit   = (r_state == c_ST_READ) ? c_READ_LIM : c_WRITE_LIM;

  ram_wait_counter #(
    .CNT_W (c_CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_ram_addr   <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_wr_done    <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_ram_addr <= req_addr;
            r_wdata    <= req_wdata;
            r_rd_en    <= !req_write;
            r_wr_en    <= req_write;
            r_state    <= req_write ? c_ST_WRITE : c_ST_READ;
          end
        end
        c_ST_READ: begin
          if (w_last) begin
            r_resp_rdata <= ram_data;
            r_rd_en      <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= c_ST_RESP;
          end
        end
        c_ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= c_ST_IDLE;
        end
        c_ST_WRITE: begin
          if (w_last) begin
            r_wr_en   <= 1'b0;
            r_wr_done <= 1'b1;
            r_state   <= c_ST_TURN;
          end
        end
        c_ST_TURN: begin
          r_wr_done <= 1'b0;
          r_state   <= c_ST_IDLE;
        end
        default: begin
          r_rd_en      <= 1'b0;
          r_wr_en      <= 1'b0;
          r_resp_valid <= 1'b0;
          r_wr_done    <= 1'b0;
          r_state      <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_rd_en  = r_rd_en;
  assign ram_wr_en  = r_wr_en;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign wr_done    = r_wr_done;

  // The bus is only ever driven while the write enable is registered high.
  assign ram_data = r_wr_en ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_ram_bus_master : directed scoreboard bench for ram_bus_master    |
// | Revision          : 1.0                                             |
// +---------------------------------------------------------------------+
module tb_ram_bus_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          wr_done;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic          ram_wr_en;
  wire  [DW-1:0] ram_data;

  logic          d4_rst = 1'b1;
  logic          d4_req_valid = 1'b0;
  logic [AW-1:0] d4_req_addr = '0;
  logic          d4_req_ready;
  logic          d4_resp_valid;
  logic [DW-1:0] d4_resp_rdata;
  logic          d4_wr_done;
  logic [AW-1:0] d4_ram_addr;
  logic          d4_rd_en;
  logic          d4_wr_en;
  wire  [DW-1:0] d4_ram_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  int            waited;

  always #5 clk = ~clk;

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .WRITE_CYC(WC)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wr_done(wr_done),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_data(ram_data)
  );

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(4), .WRITE_CYC(WC)) u_dut4 (
    .clk(clk), .rst(d4_rst), .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req_write(1'b0), .req_addr(d4_req_addr), .req_wdata('0),
    .resp_valid(d4_resp_valid), .resp_rdata(d4_resp_rdata), .wr_done(d4_wr_done),
    .ram_addr(d4_ram_addr), .ram_rd_en(d4_rd_en), .ram_wr_en(d4_wr_en),
    .ram_data(d4_ram_data)
  );

  // RAM models: combinational read while enabled, write on the clock edge.
  assign ram_data    = ram_rd_en ? mem[ram_addr] : {DW{1'bz}};
  assign d4_ram_data = d4_rd_en  ? 32'h1234_5678 : {DW{1'bz}};

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("enable_exclusive", {63'd0, ram_rd_en & ram_wr_en}, 64'd0);
      if (resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
        else check("resp_rdata", {32'd0, resp_rdata}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // Called at a negedge: drive the request, wait for ready, accept on the next edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int nwait);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    nwait = 0;
    while (!req_ready && nwait < 20) begin
      @(negedge clk);
      nwait++;
    end
    if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d, waited);
    req_valid = 1'b0;
    for (int k = 1; k <= WC; k++) begin
      @(negedge clk);
      check("wr_en_hi", {63'd0, ram_wr_en}, 64'd1);
      check("wr_rd_en", {63'd0, ram_rd_en}, 64'd0);
      check("wr_addr", {56'd0, ram_addr}, {56'd0, a});
      check("wr_data", {32'd0, ram_data}, {32'd0, d});
    end
    @(negedge clk);
    check("wr_en_lo", {63'd0, ram_wr_en}, 64'd0);
    check("wr_done_hi", {63'd0, wr_done}, 64'd1);
    @(negedge clk);
    check("wr_done_lo", {63'd0, wr_done}, 64'd0);
    check("wr_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, output int nwait);
    exp_q.push_back(e);
    issue(1'b0, a, '0, nwait);
    req_valid = 1'b0;
    for (int k = 1; k <= RL; k++) begin
      @(negedge clk);
      check("rd_en_hi", {63'd0, ram_rd_en}, 64'd1);
      check("rd_wr_en", {63'd0, ram_wr_en}, 64'd0);
      check("rd_addr", {56'd0, ram_addr}, {56'd0, a});
      check("rd_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    @(negedge clk);
    check("rd_en_lo", {63'd0, ram_rd_en}, 64'd0);
    check("resp_valid_hi", {63'd0, resp_valid}, 64'd1);
    @(negedge clk);
    check("resp_valid_lo", {63'd0, resp_valid}, 64'd0);
    check("rd_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    req_valid = 1'b1; req_addr = 8'h55; req_wdata = 32'hDEAD_BEEF; req_write = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd0);
      check("rst_rd_en", {63'd0, ram_rd_en}, 64'd0);
      check("rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_wr_done", {63'd0, wr_done}, 64'd0);
      check("rst_ram_addr", {56'd0, ram_addr}, 64'd0);
      check("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    end
    rst = 1'b0; d4_rst = 1'b0; req_valid = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_idle", {62'd0, ram_rd_en, ram_wr_en}, 64'd0);

    do_write(8'hAA, 32'h0000_DDAA);
    do_read(8'hAA, 32'h0000_DDAA, waited);

    do_write(8'h00, 32'h0000_FFFF);
    do_read(8'h00, 32'h0000_FFFF, waited);
    check("b2b_wait", 64'(waited), 64'd0);

    // Held request: address changes after acceptance must be ignored.
    exp_q.push_back(32'h0000_DDAA);
    issue(1'b0, 8'hAA, '0, waited);
    req_addr = 8'h00;
    exp_q.push_back(32'h0000_FFFF);
    for (int k = 1; k <= RL + 1; k++) begin
      @(negedge clk);
      check("hold_not_ready", {63'd0, req_ready}, 64'd0);
      if (k <= RL) check("hold_addr1", {56'd0, ram_addr}, 64'hAA);
    end
    @(negedge clk);
    check("hold_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("hold_addr2", {56'd0, ram_addr}, 64'h00);
    check("hold_rd_en2", {63'd0, ram_rd_en}, 64'd1);
    repeat (RL + 1) @(negedge clk);
    check("hold_resp_drained", 64'(exp_q.size()), 64'd0);

    // Reset during cycle 1 of a READ_LAT=4 read.
    d4_req_valid = 1'b1; d4_req_addr = 8'h10;
    check("d4_ready", {63'd0, d4_req_ready}, 64'd1);
    @(posedge clk);
    #1 d4_req_valid = 1'b0;
    @(negedge clk);
    check("d4_rd_en_c1", {63'd0, d4_rd_en}, 64'd1);
    d4_rst = 1'b1;
    @(negedge clk);
    check("d4_rd_en_rst", {63'd0, d4_rd_en}, 64'd0);
    check("d4_wr_en_rst", {63'd0, d4_wr_en}, 64'd0);
    check("d4_ready_rst", {63'd0, d4_req_ready}, 64'd0);
    d4_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("d4_no_resp", {62'd0, d4_resp_valid, d4_wr_done}, 64'd0);
      check("d4_idle_ready", {63'd0, d4_req_ready}, 64'd1);
      check("d4_rd_en_idle", {63'd0, d4_rd_en}, 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bus_master.md
# ram_bus_master

Initiator-side controller for the shared 32-bit RAM bus: accepts single read/write requests from the core over a valid/ready handshake and drives the RAM's address, read-enable, write-enable and bidirectional data lines with fixed, parameterised access timing. Sits between the CPU datapath and the `Ram` instance, owning bus direction so the RAM and core never drive `data` simultaneously.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 32, data bus width
- `READ_LAT`, 2, cycles `ram_rd_en` is held before read data is sampled (≥1)
- `WRITE_CYC`, 1, cycles `ram_wr_en` and write data are held (≥1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core request present
- `req_ready`  out  1  controller can accept a request this cycle
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data
- `resp_valid`  out  1  one-cycle pulse, `resp_rdata` valid
- `resp_rdata`  out  DATA_W  read data
- `wr_done`  out  1  one-cycle pulse, write completed
- `ram_addr`  out  ADDR_W  RAM address
- `ram_rd_en`  out  1  RAM read enable
- `ram_wr_en`  out  1  RAM write enable
- `ram_data`  inout  DATA_W  RAM data bus; driven only while `ram_wr_en`=1, else high-Z

## Operation
- FSM states: IDLE, READ, RESP, WRITE, TURN.
- IDLE: `req_ready`=1 (forced 0 while `rst`=1). On `req_valid && req_ready` latch addr, write flag, wdata; clear wait counter; go READ or WRITE.
- READ: `ram_rd_en`=1, `ram_addr`=latched addr; counter counts 1..READ_LAT; on the edge ending cycle READ_LAT, `resp_rdata` <= `ram_data`, go RESP.
- RESP: `resp_valid`=1 one cycle, enables low; next IDLE. No back-pressure on response.
- WRITE: `ram_wr_en`=1, `ram_addr`=latched addr, `ram_data`=latched wdata for WRITE_CYC cycles; then TURN.
- TURN: enables low, bus high-Z (turnaround), `wr_done`=1 one cycle; next IDLE.
- Requests while not IDLE are not accepted (`req_ready`=0); core must hold request.
- `req_write`, `req_addr`, `req_wdata` are only sampled at acceptance; later changes are ignored.
- Counter width `$clog2(max(READ_LAT,WRITE_CYC))+1`; no wrap inside a transaction.
- `ram_rd_en` and `ram_wr_en` are never both 1; bus never driven in any state except WRITE.

## Timing
- All outputs except `ram_data` tri-state and `req_ready` are registered; `req_ready` decodes state.
- Reset values: state IDLE, `ram_rd_en`=0, `ram_wr_en`=0, `ram_addr`=0, `ram_data`=Z, `resp_valid`=0, `resp_rdata`=0, `wr_done`=0.
- Accept at edge 0. Read: cycles 1..READ_LAT `ram_rd_en`=1; `resp_valid` in cycle READ_LAT+1; `req_ready`=1 again in cycle READ_LAT+2.
- Write: cycles 1..WRITE_CYC `ram_wr_en`=1 with data; `wr_done` in cycle WRITE_CYC+1; `req_ready`=1 in cycle WRITE_CYC+2.
- Back-to-back: new request accepted in the first IDLE cycle; minimum gap one idle cycle between transactions.
- Reset mid-transaction: on the reset edge all enables drop, bus goes Z, no `resp_valid`/`wr_done` for the aborted access; latched request discarded.
- `rst` and `req_valid` together: reset wins, nothing accepted.

## Structure
- Shared package `ram_bus_pkg`: state enum, default ADDR_W/DATA_W, READ_LAT/WRITE_CYC defaults.
- One natural sub-module: `ram_wait_counter` (load/clear, count, terminal-count flag at programmable limit), used for both READ and WRITE phases.

## Test plan
- Reset: assert `rst` 3 cycles with `req_valid`=1 -> all outputs at reset values, `req_ready`=0, bus Z, no access.
- Write A=0xAA, D=0x0000DDAA -> `ram_wr_en`=1 exactly WRITE_CYC cycles with `ram_data`=0x0000DDAA, `ram_addr`=0xAA; `wr_done` pulse next cycle; bus Z after.
- Read A=0xAA with RAM model returning stored value after READ_LAT=2 -> `resp_valid` in cycle 3 with `resp_rdata`=0x0000DDAA; `ram_rd_en` high cycles 1-2 only.
- Write 0x00←0x0000FFFF then immediate read 0x00 -> read accepted in first IDLE cycle after TURN; `resp_rdata`=0x0000FFFF; no cycle with both enables high or bus contention.
- Hold `req_valid`=1 during a read with changing `req_addr` -> second request accepted only when `req_ready`=1, using addr present at acceptance.
- `rst` asserted in cycle 1 of a READ_LAT=4 read -> enables low next cycle, no `resp_valid`, FSM IDLE after reset release.
